// File: rtl/ltssm_pkg.sv
// Shared substate codes, LPIF encodings and rate helpers for the LTSSM coordinator.
package ltssm_pkg;

    localparam int unsigned SUBSTATE_W    = 4;
    localparam int unsigned LPIF_W        = 4;
    localparam int unsigned GEN_W         = 3;
    localparam int unsigned RATE_W        = 8;
    localparam int unsigned RCNT_W        = 8;
    localparam int unsigned MAX_GEN_LIMIT = 5;

    typedef enum logic [SUBSTATE_W-1:0] {
        DETECT_QUIET          = 4'd0,
        DETECT_ACTIVE         = 4'd1,
        POLLING_ACTIVE        = 4'd2,
        POLLING_CONFIGURATION = 4'd3,
        CFG_LINKWIDTH_START   = 4'd4,
        CFG_LINKWIDTH_ACCEPT  = 4'd5,
        CFG_LANENUM_WAIT      = 4'd6,
        CFG_LANENUM_ACCEPT    = 4'd7,
        CFG_COMPLETE          = 4'd8,
        CFG_IDLE              = 4'd9,
        L0                    = 4'd10,
        RECOVERY_RCVR_LOCK    = 4'd11,
        RECOVERY_RCVR_CFG     = 4'd12,
        RECOVERY_SPEED        = 4'd13,
        RECOVERY_IDLE         = 4'd14
    } substate_e;

    localparam logic [LPIF_W-1:0] LPIF_RESET   = 4'd0;
    localparam logic [LPIF_W-1:0] LPIF_ACTIVE  = 4'd1;
    localparam logic [LPIF_W-1:0] LPIF_RETRAIN = 4'd2;

    localparam logic [RATE_W-1:0] RATE_ID_RESET = 8'h02;

    // Highest advertised generation not above max_gen; never below Gen 1.
    function automatic logic [GEN_W-1:0] target_gen(input logic [RATE_W-1:0] rate_id,
                                                     input int unsigned         max_gen);
        logic [GEN_W-1:0] tg;
        tg = GEN_W'(1);
        for (int unsigned g = 1; g <= MAX_GEN_LIMIT; g++) begin
            if (g <= max_gen && rate_id[g]) begin
                tg = GEN_W'(g);
            end
        end
        return tg;
    endfunction

endpackage

// File: rtl/ltssm_timeout_timer.sv
// Per-substate watchdog: counts while enabled, expire_c strobes on the last allowed cycle.
module ltssm_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c = enable_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/ltssm_main_ctrl.sv
// Top-level LTSSM coordinator: keeps Tx/Rx sub-LTSSMs in lock-step, handles
// training, Recovery/rate change, LPIF requests and the substate watchdog.
module ltssm_main_ctrl
    import ltssm_pkg::*;
#(
    parameter int unsigned DEVICETYPE     = 0,
    parameter int unsigned MAXGEN         = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LPIF_W-1:0]     lpifStateRequest,
    input  logic                  finishTx,
    input  logic                  finishRx,
    input  logic [SUBSTATE_W-1:0] gotoTx,
    input  logic [SUBSTATE_W-1:0] gotoRx,
    input  logic                  forceDetect,
    input  logic [RATE_W-1:0]     rateIdIn,
    input  logic                  writeRateId,
    output logic                  linkUp,
    output logic [GEN_W-1:0]      GEN,
    output logic [LPIF_W-1:0]     lpifStateStatus,
    output logic [SUBSTATE_W-1:0] substateTx,
    output logic [SUBSTATE_W-1:0] substateRx,
    output logic                  timeoutEvent,
    output logic [RCNT_W-1:0]     recoveryCount
);

    substate_e         state_q, state_d;
    logic              link_q, link_d;
    logic [GEN_W-1:0]  gen_q, gen_d;
    logic [LPIF_W-1:0] status_q, status_d;
    logic              tevt_q, tevt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [RATE_W-1:0] rate_q, rate_d;

    logic              to_dq;
    logic              both_c;
    logic              fail_c;
    logic              exempt_c;
    logic              in_recovery_c;
    logic              expire_c;
    logic [GEN_W-1:0]  tgt_gen_c;
    substate_e         seq_next_c;

    assign both_c        = finishTx && finishRx && (gotoTx == gotoRx);
    assign fail_c        = (finishTx && (gotoTx == DETECT_QUIET)) ||
                           (finishRx && (gotoRx == DETECT_QUIET));
    assign exempt_c      = (state_q == DETECT_QUIET) || (state_q == L0);
    assign in_recovery_c = (state_q >= RECOVERY_RCVR_LOCK) && (state_q <= RECOVERY_IDLE);
    assign tgt_gen_c     = target_gen(rate_q, MAXGEN);
    assign seq_next_c    = substate_e'(SUBSTATE_W'(state_q) + SUBSTATE_W'(1));

    ltssm_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (state_d != state_q),
        .enable_i(!exempt_c),
        .expire_c(expire_c)
    );

    // rateId latch; a write coinciding with a Recovery decision only affects later ones.
    always_comb begin
        rate_d = rate_q;
        if (writeRateId) begin
            rate_d = rateIdIn;
        end
    end

    // Next-state: forceDetect > failure goto > legal advance > watchdog.
    always_comb begin
        state_d  = state_q;
        link_d   = link_q;
        gen_d    = gen_q;
        status_d = status_q;
        tevt_d   = 1'b0;
        rcnt_d   = rcnt_q;
        to_dq    = 1'b0;

        if (forceDetect) begin
            to_dq = 1'b1;
        end else if (fail_c) begin
            to_dq = 1'b1;
            if (!in_recovery_c) begin
                gen_d = GEN_W'(1);
            end
        end else begin
            unique case (state_q)
                DETECT_QUIET, DETECT_ACTIVE, POLLING_ACTIVE,
                POLLING_CONFIGURATION, CFG_COMPLETE: begin
                    if (both_c && (gotoTx == seq_next_c)) begin
                        state_d = seq_next_c;
                    end
                end
                CFG_LINKWIDTH_START, CFG_LANENUM_WAIT, CFG_LANENUM_ACCEPT: begin
                    if (finishRx && (gotoRx == seq_next_c)) begin
                        state_d = seq_next_c;
                    end
                end
                CFG_LINKWIDTH_ACCEPT: begin
                    if ((DEVICETYPE == 0) ? (finishTx && (gotoTx == CFG_LANENUM_WAIT))
                                          : (both_c && (gotoTx == CFG_LANENUM_WAIT))) begin
                        state_d = CFG_LANENUM_WAIT;
                    end
                end
                CFG_IDLE: begin
                    // Trained link parks here until the adapter asks for active.
                    if (link_q) begin
                        if (lpifStateRequest == LPIF_ACTIVE) begin
                            state_d  = L0;
                            status_d = LPIF_ACTIVE;
                        end
                    end else if (both_c && (gotoTx == L0)) begin
                        link_d = 1'b1;
                    end
                end
                L0: begin
                    if (lpifStateRequest == LPIF_RESET) begin
                        state_d  = DETECT_QUIET;
                        link_d   = 1'b0;
                        gen_d    = GEN_W'(1);
                        status_d = LPIF_RESET;
                    end else if ((lpifStateRequest == LPIF_RETRAIN) ||
                                 (finishTx && (gotoTx == RECOVERY_RCVR_LOCK)) ||
                                 (finishRx && (gotoRx == RECOVERY_RCVR_LOCK))) begin
                        state_d  = RECOVERY_RCVR_LOCK;
                        status_d = LPIF_RETRAIN;
                        if (rcnt_q != '1) begin
                            rcnt_d = rcnt_q + RCNT_W'(1);
                        end
                    end
                end
                RECOVERY_RCVR_LOCK: begin
                    if (both_c && (gotoTx == RECOVERY_RCVR_CFG)) begin
                        state_d = RECOVERY_RCVR_CFG;
                    end
                end
                RECOVERY_RCVR_CFG: begin
                    if (both_c && ((gotoTx == RECOVERY_SPEED) || (gotoTx == RECOVERY_IDLE))) begin
                        state_d = (tgt_gen_c != gen_q) ? RECOVERY_SPEED : RECOVERY_IDLE;
                    end
                end
                RECOVERY_SPEED: begin
                    if (both_c && (gotoTx == RECOVERY_RCVR_LOCK)) begin
                        state_d = RECOVERY_RCVR_LOCK;
                        gen_d   = tgt_gen_c;
                    end
                end
                RECOVERY_IDLE: begin
                    if (both_c && (gotoTx == L0)) begin
                        state_d  = L0;
                        status_d = LPIF_ACTIVE;
                    end
                end
                default: begin
                    to_dq = 1'b1;
                end
            endcase

            if ((state_d == state_q) && expire_c) begin
                to_dq  = 1'b1;
                tevt_d = 1'b1;
            end
        end

        if (to_dq) begin
            state_d  = DETECT_QUIET;
            link_d   = 1'b0;
            status_d = LPIF_RESET;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= DETECT_QUIET;
            link_q   <= 1'b0;
            gen_q    <= GEN_W'(1);
            status_q <= LPIF_RESET;
            tevt_q   <= 1'b0;
            rcnt_q   <= '0;
            rate_q   <= RATE_ID_RESET;
        end else begin
            state_q  <= state_d;
            link_q   <= link_d;
            gen_q    <= gen_d;
            status_q <= status_d;
            tevt_q   <= tevt_d;
            rcnt_q   <= rcnt_d;
            rate_q   <= rate_d;
        end
    end

    assign linkUp          = link_q;
    assign GEN             = gen_q;
    assign lpifStateStatus = status_q;
    assign substateTx      = state_q;
    assign substateRx      = state_q;
    assign timeoutEvent    = tevt_q;
    assign recoveryCount   = rcnt_q;

endmodule
